// File: rtl/io_fifo_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ valid/ready requesters,
// holding each grant for up to BURST_LEN beats. Optional watermark gating: IO_FIFO_ARB_WMARK_EN.
module io_fifo_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int BURST_LEN  = 4,
    parameter int ID_WIDTH   = $clog2(NUM_REQ),
    parameter int CNT_WIDTH  = $clog2(BURST_LEN + 1)
`ifdef IO_FIFO_ARB_WMARK_EN
    ,
    parameter int FIFO_DEPTH = 8,
    parameter int HIGH_WMARK = FIFO_DEPTH - 1
`endif
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clr_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic                          fifo_valid_o,
    output logic [DATA_WIDTH-1:0]         fifo_data_o,
    output logic [ID_WIDTH-1:0]           fifo_id_o,
    input  logic                          fifo_ready_i,
`ifdef IO_FIFO_ARB_WMARK_EN
    input  logic [$clog2(FIFO_DEPTH):0]   fifo_elements_i,
`endif
    output logic                          busy_o
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [ID_WIDTH-1:0]  LAST_REQ  = ID_WIDTH'(NUM_REQ - 1);
    localparam logic [ID_WIDTH:0]    NUM_REQ_W = (ID_WIDTH + 1)'(NUM_REQ);
    localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(BURST_LEN - 1);

    state_t                state_q, state_d;
    logic [ID_WIDTH-1:0]   grant_q, grant_d;
    logic [ID_WIDTH-1:0]   last_q, last_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    logic [ID_WIDTH-1:0]   start;
    logic [ID_WIDTH:0]     cand;
    logic                  win_found;
    logic [ID_WIDTH-1:0]   win_id;
    logic                  sel_valid;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  busy;
    logic                  hs;
    logic                  grant_ok;

`ifdef IO_FIFO_ARB_WMARK_EN
    localparam int                EW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [EW-1:0]     WMARK_L = EW'(HIGH_WMARK);
    assign grant_ok = (fifo_elements_i < WMARK_L);
`else
    assign grant_ok = 1'b1;
`endif

    assign start = (last_q == LAST_REQ) ? '0 : last_q + ID_WIDTH'(1);

    // Scan from the highest offset down so the lowest offset past last_q wins.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = {1'b0, start} + (ID_WIDTH + 1)'(i);
            if (cand >= NUM_REQ_W) begin
                cand = cand - NUM_REQ_W;
            end
            for (int j = 0; j < NUM_REQ; j++) begin
                if (cand == (ID_WIDTH + 1)'(j) && req_valid_i[j]) begin
                    win_found = 1'b1;
                    win_id    = ID_WIDTH'(j);
                end
            end
        end
    end

    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q == ID_WIDTH'(i)) begin
                sel_valid = req_valid_i[i];
                sel_data  = req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign busy         = (state_q == BUSY);
    assign busy_o       = busy;
    assign fifo_valid_o = busy && sel_valid;
    assign fifo_data_o  = busy ? sel_data : '0;
    assign fifo_id_o    = busy ? grant_q : '0;
    assign hs           = fifo_valid_o && fifo_ready_i;

    always_comb begin
        req_ready_o = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready_o[i] = busy && fifo_ready_i && (grant_q == ID_WIDTH'(i));
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (win_found && grant_ok) begin
                    grant_d = win_id;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (hs) begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                    if (cnt_q == LAST_BEAT) begin
                        state_d = IDLE;
                        last_d  = grant_q;
                    end
                end else if (!sel_valid) begin
                    // Holder went idle: give others a turn instead of waiting for it.
                    state_d = IDLE;
                    last_d  = grant_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= LAST_REQ;
            cnt_q   <= '0;
        end else if (clr_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= LAST_REQ;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_io_fifo_arbiter.sv
// Scoreboard bench for io_fifo_arbiter: one instance with BURST_LEN=4, one with BURST_LEN=1.
module tb_io_fifo_arbiter;
    localparam int NR = 4;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;
    logic clr;
    logic [1:0][NR-1:0]    rv;
    logic [1:0][NR-1:0]    rr;
    logic [1:0][NR*DW-1:0] rd;
    logic [1:0]            fv;
    logic [1:0]            fr;
    logic [1:0]            busy;
    logic [1:0][DW-1:0]    fd;
    logic [1:0][1:0]       fid;
`ifdef IO_FIFO_ARB_WMARK_EN
    logic [3:0]            elems;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int hs_cnt[2] = '{0, 0};
    int cyc = 0;
    int last_hs_b = -1;
    int base;
    logic [31:0] srcq[8][$];
    logic [33:0] expq[2][$];

    always #5 clk = ~clk;

    io_fifo_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .BURST_LEN(4)) u_dut4 (
        .clk(clk), .rst(rst), .clr_i(clr),
        .req_valid_i(rv[0]), .req_data_i(rd[0]), .req_ready_o(rr[0]),
        .fifo_valid_o(fv[0]), .fifo_data_o(fd[0]), .fifo_id_o(fid[0]),
        .fifo_ready_i(fr[0]),
`ifdef IO_FIFO_ARB_WMARK_EN
        .fifo_elements_i(elems),
`endif
        .busy_o(busy[0])
    );

    io_fifo_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .BURST_LEN(1)) u_dut1 (
        .clk(clk), .rst(rst), .clr_i(clr),
        .req_valid_i(rv[1]), .req_data_i(rd[1]), .req_ready_o(rr[1]),
        .fifo_valid_o(fv[1]), .fifo_data_o(fd[1]), .fifo_id_o(fid[1]),
        .fifo_ready_i(fr[1]),
`ifdef IO_FIFO_ARB_WMARK_EN
        .fifo_elements_i(elems),
`endif
        .busy_o(busy[1])
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: every FIFO handshake pops and checks the next expected {id,data}
    always @(negedge clk) begin
        logic [33:0] e;
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (fv[i] && fr[i]) begin
                if (expq[i].size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL beat%0d_unexpected: got id %0d data 0x%0h, want none", i, fid[i], fd[i]);
                end else begin
                    e = expq[i].pop_front();
                    chk($sformatf("beat%0d", i), {30'd0, fid[i], fd[i]}, {30'd0, e});
                end
                hs_cnt[i]++;
                if (i == 1) begin
                    if (last_hs_b >= 0) chk("rr_gap", 64'(cyc - last_hs_b), 64'd2);
                    last_hs_b = cyc;
                end
            end
        end
    end

    // Requester models: present the head of each source queue, pop on accepted beats
    task automatic refresh();
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < NR; k++) begin
                rv[i][k] = (srcq[i*NR+k].size() != 0);
                rd[i][k*DW +: DW] = rv[i][k] ? srcq[i*NR+k][0] : '0;
            end
        end
    endtask

    initial begin
        logic [1:0][NR-1:0] acc;
        refresh();
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) acc[i] = rv[i] & rr[i];
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++)
                for (int k = 0; k < NR; k++)
                    if (acc[i][k]) void'(srcq[i*NR+k].pop_front());
            refresh();
            #2;
            refresh();
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic src(input int i, input int k, input logic [31:0] d);
        srcq[i*NR+k].push_back(d);
    endtask

    task automatic ex(input int i, input logic [1:0] id, input logic [31:0] d);
        expq[i].push_back({id, d});
    endtask

    task automatic wait_hs(input int i, input int target, input int budget);
        int c = 0;
        while (hs_cnt[i] < target && c < budget) begin
            step();
            c++;
        end
        chk($sformatf("wait_hs%0d", i), 64'(hs_cnt[i] >= target), 64'd1);
    endtask

    initial begin
        rst = 1'b1;
        clr = 1'b0;
        fr  = 2'b11;
`ifdef IO_FIFO_ARB_WMARK_EN
        elems = '0;
`endif
        step();
        step();
        chk("rst_valid", 64'(fv[0]), 64'd0);
        chk("rst_ready", 64'(rr[0]), 64'd0);
        chk("rst_data",  64'(fd[0]), 64'd0);
        chk("rst_id",    64'(fid[0]), 64'd0);
        chk("rst_busy",  64'(busy), 64'd0);
        rst = 1'b0;
        step();

        // Burst: req2 sends 8 beats as two bursts of 4
        for (int j = 0; j < 8; j++) begin
            src(0, 2, 32'hA0 + j);
            ex(0, 2'd2, 32'hA0 + j);
        end
        wait_hs(0, 8, 60);

        // Backpressure mid-burst; C1 arrival exposes a wrongly advanced beat count
        base = hs_cnt[0];
        src(0, 3, 32'hC0);
        ex(0, 2'd3, 32'hC0);
        for (int j = 0; j < 6; j++) src(0, 2, 32'hB0 + j);
        for (int j = 0; j < 4; j++) ex(0, 2'd2, 32'hB0 + j);
        wait_hs(0, base + 2, 40);
        fr[0] = 1'b0;
        src(0, 3, 32'hC1);
        ex(0, 2'd3, 32'hC1);
        ex(0, 2'd2, 32'hB4);
        ex(0, 2'd2, 32'hB5);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            chk("bp_ready", 64'(rr[0]), 64'd0);
            chk("bp_busy",  64'(busy[0]), 64'd1);
            chk("bp_id",    64'(fid[0]), 64'd2);
            chk("bp_data",  64'(fd[0]), 64'hB1);
        end
        step();
        fr[0] = 1'b1;
        wait_hs(0, base + 8, 60);

        // Early release: req1 gives 2 of 4 beats; req3 then req0 follow
        base = hs_cnt[0];
        src(0, 1, 32'hD0);
        src(0, 1, 32'hD1);
        ex(0, 2'd1, 32'hD0);
        ex(0, 2'd1, 32'hD1);
        wait_hs(0, base + 1, 20);
        src(0, 3, 32'hE0);
        src(0, 0, 32'hF0);
        ex(0, 2'd3, 32'hE0);
        ex(0, 2'd0, 32'hF0);
        wait_hs(0, base + 4, 40);

        // Asynchronous reset mid-burst: G2 is not transferred, req0 wins after reset
        base = hs_cnt[0];
        for (int j = 0; j < 4; j++) src(0, 2, 32'h60 + j);
        ex(0, 2'd2, 32'h60);
        ex(0, 2'd2, 32'h61);
        wait_hs(0, base + 2, 20);
        chk("pre_rst_busy", 64'(busy[0]), 64'd1);
        rst = 1'b1;
        #1;
        chk("arst_valid", 64'(fv[0]), 64'd0);
        chk("arst_ready", 64'(rr[0]), 64'd0);
        chk("arst_data",  64'(fd[0]), 64'd0);
        chk("arst_id",    64'(fid[0]), 64'd0);
        chk("arst_busy",  64'(busy[0]), 64'd0);
        src(0, 0, 32'h80);
        ex(0, 2'd0, 32'h80);
        ex(0, 2'd2, 32'h62);
        ex(0, 2'd2, 32'h63);
        step();
        step();
        rst = 1'b0;
        wait_hs(0, base + 5, 40);

        // clr_i together with a handshake: beat J1 kept, arbiter restarts from req0
        base = hs_cnt[0];
        for (int j = 0; j < 4; j++) src(0, 1, 32'h90 + j);
        ex(0, 2'd1, 32'h90);
        ex(0, 2'd1, 32'h91);
        wait_hs(0, base + 1, 20);
        clr = 1'b1;
        src(0, 0, 32'h70);
        src(0, 3, 32'h50);
        ex(0, 2'd0, 32'h70);
        ex(0, 2'd1, 32'h92);
        ex(0, 2'd1, 32'h93);
        ex(0, 2'd3, 32'h50);
        step();
        chk("clr_busy",  64'(busy[0]), 64'd0);
        chk("clr_valid", 64'(fv[0]), 64'd0);
        clr = 1'b0;
        wait_hs(0, base + 6, 60);

        // Per-beat round robin on the BURST_LEN=1 instance
        base = hs_cnt[1];
        for (int j = 0; j < 2; j++)
            for (int k = 0; k < NR; k++) begin
                src(1, k, 32'h100 * k + j);
                ex(1, 2'(k), 32'h100 * k + j);
            end
        wait_hs(1, base + 8, 60);

`ifdef IO_FIFO_ARB_WMARK_EN
        base = hs_cnt[0];
        elems = 4'd7;
        src(0, 0, 32'hD00D);
        ex(0, 2'd0, 32'hD00D);
        for (int c = 0; c < 3; c++) begin
            step();
            chk("wmark_hold", 64'(busy[0]), 64'd0);
        end
        elems = 4'd6;
        step();
        chk("wmark_grant", 64'(busy[0]), 64'd1);
        wait_hs(0, base + 1, 20);
`endif

        for (int c = 0; c < 50 && (expq[0].size() + expq[1].size()) != 0; c++) step();
        chk("sb_drain", 64'(expq[0].size() + expq[1].size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/io_fifo_arbiter.md
Name: io_fifo_arbiter

Overview:
- Round-robin arbiter that shares the write port of one io_generic_fifo between NUM_REQ valid/ready requesters.
- A granted requester keeps the port for up to BURST_LEN accepted beats, so its burst is not interleaved with other requesters.
- Each beat is tagged with the source index so the consumer side can demultiplex.
- Sits between peripheral producers (e.g. UART/SPI RX engines) and the shared FIFO.

Parameters:
- NUM_REQ, 4: number of requesters, 2..16.
- DATA_WIDTH, 32: beat width; matches the FIFO DATA_WIDTH.
- BURST_LEN, 4: maximum accepted beats per grant, 1..256.
- ID_WIDTH, $clog2(NUM_REQ): width of the source tag.
- CNT_WIDTH, $clog2(BURST_LEN+1): width of the beat counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- clr_i  in  1  synchronous clear; same effect as reset.
- req_valid_i  in  NUM_REQ  per-requester valid.
- req_data_i  in  NUM_REQ*DATA_WIDTH  packed data; requester k occupies [k*DATA_WIDTH +: DATA_WIDTH].
- req_ready_o  out  NUM_REQ  per-requester ready.
- fifo_valid_o  out  1  to FIFO valid_i.
- fifo_data_o  out  DATA_WIDTH  to FIFO data_i.
- fifo_id_o  out  ID_WIDTH  index of the current grant holder.
- fifo_ready_i  in  1  from FIFO ready_o.
- busy_o  out  1  high in state BUSY.

Behaviour:
- State machine: IDLE, BUSY. Registers: state, grant_id, last_id, beat_cnt.
- Reset / clr_i values: state=IDLE, grant_id=0, last_id=NUM_REQ-1, beat_cnt=0.
- Output values after reset or clear: fifo_valid_o=0, req_ready_o=0, fifo_data_o=0, fifo_id_o=0, busy_o=0.
- IDLE:
  - All outputs are 0.
  - If any req_valid_i bit is set, the winner is the first set bit searching upward from (last_id+1) mod NUM_REQ, wrapping.
  - On a winner: grant_id<=winner, beat_cnt<=0, state<=BUSY.
  - Arbitration latency is 1 cycle; no data passes in the IDLE cycle.
- BUSY (all outputs combinational from grant_id):
  - fifo_valid_o = req_valid_i[grant_id].
  - fifo_data_o = the grant_id slice of req_data_i.
  - fifo_id_o = grant_id.
  - req_ready_o = fifo_ready_i on bit grant_id only; all other bits 0.
- Handshake (hs): fifo_valid_o && fifo_ready_i. On each hs, beat_cnt increments.
- Release: BUSY -> IDLE with last_id<=grant_id when either:
  - hs occurs and beat_cnt==BURST_LEN-1, or
  - req_valid_i[grant_id]==0 (no hs that cycle).
- No release on backpressure: fifo_ready_i low while the holder is valid keeps the grant and beat_cnt unchanged.
- Data and valid pass straight through; the arbiter never drops or duplicates a beat.
- Fairness: a requester that stays valid is granted within NUM_REQ arbitrations.
- BURST_LEN=1: release after every hs, giving pure per-beat round-robin with an IDLE bubble between grants.
- Non-grant requesters' valid changes while BUSY are ignored.
- Reset asserted mid-burst: state returns to IDLE immediately (asynchronous). A beat not yet handshaken is not transferred.
- clr_i with hs in the same cycle: the hs beat is accepted by the FIFO; the arbiter state is still cleared.

Optional Feature:
- Macro: IO_FIFO_ARB_WMARK_EN.
- When defined, adds ports fifo_elements_i (input, $clog2(FIFO_DEPTH)+1 bits) and parameters FIFO_DEPTH (default 8) and HIGH_WMARK (default FIFO_DEPTH-1).
- In IDLE, no new grant is issued while fifo_elements_i >= HIGH_WMARK; a grant in progress is unaffected.
- When undefined, those ports and parameters do not exist and grants depend only on req_valid_i.

Test Plan:
- Reset: assert rst asynchronously between clock edges -> all outputs 0 at once; first grant after release goes to requester 0.
- Round-robin: NUM_REQ=4, BURST_LEN=1, all valid, fifo_ready_i=1 -> fifo_id_o sequence 0,1,2,3,0 with one IDLE cycle between beats; every beat equals its source data.
- Burst: BURST_LEN=4, req 2 valid with data 0xA0..0xA7 -> the FIFO receives 0xA0..0xA3 with id 2, then IDLE, then 0xA4..0xA7 (re-granted because no one else is valid).
- Backpressure: fifo_ready_i=0 for 5 cycles mid-burst -> grant held, beat_cnt frozen, req_ready_o all 0, no data lost; burst completes after ready returns.
- Early release: req 1 drops valid after 2 of 4 beats while req 3 is valid -> BUSY to IDLE, next grant is 3, last_id=1.
- WMARK (macro on, FIFO_DEPTH=8, HIGH_WMARK=7): fifo_elements_i=7 -> stays IDLE with requests pending; fifo_elements_i=6 -> grant next cycle.
